mod_exp_ctrl: RTL

Sequencer for k-bit modular exponentiation z = base^exp mod m. It drives one external `mod_mul` instance through a start/done handshake using left-to-right square-and-multiply. It sits between the RSA top level and the `mod_mul` datapath, and is the only requester of that multiplier.

---
 rtl/mod_exp_ctrl_pkg.sv | 37 +++
 rtl/mod_exp_ctrl_if.sv | 28 ++
 rtl/mod_exp_top.sv | 43 ++++
 rtl/mod_mul.sv | 87 ++++++++
 rtl/mod_exp_ctrl.sv | 139 +++++++++++++
 5 files changed

// File: rtl/mod_exp_ctrl_pkg.sv
// Shared state encodings and helpers for the modular-exponentiation sequencer
// and the multiplier it drives.
package rsa_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SQ     = 3'd1;
  localparam logic [2:0] S_SQ_REL = 3'd2;
  localparam logic [2:0] S_MU     = 3'd3;
  localparam logic [2:0] S_MU_REL = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE   = S_IDLE,
    ST_SQ     = S_SQ,
    ST_SQ_REL = S_SQ_REL,
    ST_MU     = S_MU,
    ST_MU_REL = S_MU_REL,
    ST_DONE   = S_DONE
  } state_e;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_RUN  = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

  // Bits needed to index n items; a single-bit counter is the floor.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/mod_exp_ctrl_if.sv
// Request/response bus between the exponentiation sequencer and its modular multiplier.
interface mod_exp_ctrl_if #(
  parameter int k = 12
);

  logic [k-1:0] mm_x;
  logic [k-1:0] mm_y;
  logic         mm_start;
  logic [k-1:0] mm_z;
  logic         mm_done;

  modport master (
    output mm_x,
    output mm_y,
    output mm_start,
    input  mm_z,
    input  mm_done
  );

  modport slave (
    input  mm_x,
    input  mm_y,
    input  mm_start,
    output mm_z,
    output mm_done
  );

endinterface

// File: rtl/mod_exp_top.sv
// Exponentiation unit: the sequencer paired with its dedicated modular multiplier.
module mod_exp_top
  import rsa_pkg::*;
#(
  parameter int           k    = 12,
  parameter int           logk = clog2(k),
  parameter logic [k-1:0] m    = k'(3551)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [k-1:0] base,
  input  logic [k-1:0] exp,
  output logic [k-1:0] z,
  output logic         done,
  output logic         busy
);

  mod_exp_ctrl_if #(.k(k)) mmBus ();

  mod_exp_ctrl #(.k(k), .logk(logk), .m(m)) uCtrl (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .base  (base),
    .exp   (exp),
    .z     (z),
    .done  (done),
    .busy  (busy),
    .mm    (mmBus)
  );

  mod_mul #(.k(k), .logk(logk), .m(m)) uMul (
    .clk   (clk),
    .rst_n (rst_n),
    .x     (mmBus.mm_x),
    .y     (mmBus.mm_y),
    .start (mmBus.mm_start),
    .z     (mmBus.mm_z),
    .done  (mmBus.mm_done)
  );

endmodule

// File: rtl/mod_mul.sv
// Bit-serial interleaved modular multiplier z = x*y mod m, one y bit per cycle, MSB first.
// Operands must already be reduced below m.
module mod_mul
  import rsa_pkg::*;
#(
  parameter int           k    = 12,
  parameter int           logk = clog2(k),
  parameter logic [k-1:0] m    = k'(3551)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [k-1:0] x,
  input  logic [k-1:0] y,
  input  logic         start,
  output logic [k-1:0] z,
  output logic         done
);

  localparam logic [logk-1:0] IdxTop = logk'(k - 1);

  mul_state_e      state_q;
  logic [k-1:0]    xReg_q;
  logic [k-1:0]    yReg_q;
  logic [k-1:0]    r_q;
  logic [k-1:0]    z_q;
  logic [logk-1:0] cnt_q;
  logic            done_q;
  logic [k-1:0]    r_d;

  // Doubling then conditional add keeps r below m with two trial subtractions.
  function automatic logic [k-1:0] mulStep(input logic [k-1:0] r, input logic [k-1:0] xv,
                                           input logic bitv);
    logic [k:0] t;
    t = {r, 1'b0};
    if (t >= {1'b0, m}) t = t - {1'b0, m};
    if (bitv) t = t + {1'b0, xv};
    if (t >= {1'b0, m}) t = t - {1'b0, m};
    return t[k-1:0];
  endfunction

  assign r_d = mulStep(r_q, xReg_q, yReg_q[cnt_q]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= MUL_IDLE;
      xReg_q  <= '0;
      yReg_q  <= '0;
      r_q     <= '0;
      z_q     <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        MUL_IDLE: begin
          if (start) begin
            xReg_q  <= x;
            yReg_q  <= y;
            r_q     <= '0;
            cnt_q   <= IdxTop;
            state_q <= MUL_RUN;
          end
        end
        MUL_RUN: begin
          r_q <= r_d;
          if (cnt_q == '0) begin
            z_q     <= r_d;
            done_q  <= 1'b1;
            state_q <= MUL_DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        MUL_DONE: begin
          if (!start) begin
            done_q  <= 1'b0;
            state_q <= MUL_IDLE;
          end
        end
        default: state_q <= MUL_IDLE;
      endcase
    end
  end

  assign z    = z_q;
  assign done = done_q;

endmodule

// File: rtl/mod_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer: drives one modular multiplier
// through a level start/done handshake to compute z = base^exp mod m.
module mod_exp_ctrl
  import rsa_pkg::*;
#(
  parameter int           k    = 12,
  parameter int           logk = clog2(k),
  parameter logic [k-1:0] m    = k'(3551)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [k-1:0]   base,
  input  logic [k-1:0]   exp,
  output logic [k-1:0]   z,
  output logic           done,
  output logic           busy,
  mod_exp_ctrl_if.master mm
);

  // With m == 1 every residue is 0, so the running product starts there.
  localparam logic [k-1:0]    AccInit = (m == k'(1)) ? '0 : k'(1);
  localparam logic [logk-1:0] IdxTop  = logk'(k - 1);

  state_e          state_q;
  logic [k-1:0]    bReg_q;
  logic [k-1:0]    eReg_q;
  logic [k-1:0]    acc_q;
  logic [logk-1:0] idx_q;
  logic [k-1:0]    z_q;
  logic            done_q;
  logic            busy_q;
  logic            mmStart_q;
  logic [k-1:0]    mmX_q;
  logic [k-1:0]    mmY_q;
  logic            lastBit;

  assign lastBit = (idx_q == '0);

  // Operands are loaded in the same edge that raises mm_start and are only
  // touched again after the release, so they stay stable for the whole request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      bReg_q    <= '0;
      eReg_q    <= '0;
      acc_q     <= '0;
      idx_q     <= '0;
      z_q       <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      mmStart_q <= 1'b0;
      mmX_q     <= '0;
      mmY_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            bReg_q    <= base;
            eReg_q    <= exp;
            acc_q     <= AccInit;
            idx_q     <= IdxTop;
            mmX_q     <= AccInit;
            mmY_q     <= AccInit;
            mmStart_q <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= ST_SQ;
          end
        end
        ST_SQ: begin
          if (mm.mm_done) begin
            acc_q     <= mm.mm_z;
            mmStart_q <= 1'b0;
            state_q   <= ST_SQ_REL;
          end
        end
        ST_SQ_REL: begin
          if (!mm.mm_done) begin
            if (eReg_q[idx_q]) begin
              mmX_q     <= acc_q;
              mmY_q     <= bReg_q;
              mmStart_q <= 1'b1;
              state_q   <= ST_MU;
            end else if (lastBit) begin
              z_q     <= acc_q;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= ST_DONE;
            end else begin
              idx_q     <= idx_q - 1'b1;
              mmX_q     <= acc_q;
              mmY_q     <= acc_q;
              mmStart_q <= 1'b1;
              state_q   <= ST_SQ;
            end
          end
        end
        ST_MU: begin
          if (mm.mm_done) begin
            acc_q     <= mm.mm_z;
            mmStart_q <= 1'b0;
            state_q   <= ST_MU_REL;
          end
        end
        ST_MU_REL: begin
          if (!mm.mm_done) begin
            if (lastBit) begin
              z_q     <= acc_q;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= ST_DONE;
            end else begin
              idx_q     <= idx_q - 1'b1;
              mmX_q     <= acc_q;
              mmY_q     <= acc_q;
              mmStart_q <= 1'b1;
              state_q   <= ST_SQ;
            end
          end
        end
        ST_DONE: begin
          if (!start) begin
            done_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign z           = z_q;
  assign done        = done_q;
  assign busy        = busy_q;
  assign mm.mm_start = mmStart_q;
  assign mm.mm_x     = mmX_q;
  assign mm.mm_y     = mmY_q;

endmodule
